// File: rtl/norm_pkg.sv
// Shared ALU definitions for the left-normalizer: mode encoding and the
// bit-count op codes it borrows from cix.
package norm_pkg;

  typedef enum logic {
    NORM_LZ = 1'b0,
    NORM_LO = 1'b1
  } norm_mode_e;

  typedef enum logic [1:0] {
    CIX_CLZ = 2'd0,
    CIX_CLO = 2'd1,
    CIX_CTZ = 2'd2,
    CIX_CTO = 2'd3
  } cix_op_e;

  function automatic cix_op_e norm_cix_op(input logic mode);
    return (mode == NORM_LO) ? CIX_CLO : CIX_CLZ;
  endfunction

endpackage

// File: rtl/norm_if.sv
// Operand and result streams of the normalizer, grouped as one bundle.
// The block is the slave; whoever feeds it and drains it is the master.
interface norm_if #(parameter int ORDER = 3);
  localparam int W = 2**ORDER;

  logic           in_valid;
  logic           in_ready;
  logic           in_mode;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [ORDER:0] out_count;
  logic           out_all;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_all
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count, out_all
  );
endinterface

// File: rtl/norm_cix.sv
// Bit-count unit: leading/trailing zero or one count over a 2**ORDER word.
// o_zero flags a word that contains none of the bit being searched for.
module cix
  import norm_pkg::*;
#(
  parameter int ORDER = 3
) (
  input  cix_op_e              i_op,
  input  logic [2**ORDER-1:0]  i_data,
  output logic [ORDER:0]       o_count,
  output logic                 o_zero
);
  localparam int W  = 2**ORDER;
  localparam int CW = ORDER + 1;

  logic [W-1:0] w_inv;
  logic [W-1:0] w_scan;

  // Ones-counting reduces to zero-counting on the inverted word.
  assign w_inv = (i_op == CIX_CLO || i_op == CIX_CTO) ? ~i_data : i_data;

  always_comb begin
    w_scan = w_inv;
    if (i_op == CIX_CTZ || i_op == CIX_CTO) begin
      for (int i = 0; i < W; i++) begin
        w_scan[i] = w_inv[W-1-i];
      end
    end
  end

  always_comb begin
    o_count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (w_scan[i]) o_count = CW'(W - 1 - i);
    end
  end

  assign o_zero = (w_scan == '0);

endmodule

// File: rtl/norm_shl.sv
// Combinational left barrel shifter with ORDER+1 levels; the top level
// shifts by the full width and therefore clears the word.
module shl_norm #(
  parameter int ORDER = 3
) (
  input  logic [2**ORDER-1:0] i_data,
  input  logic [ORDER:0]      i_count,
  output logic [2**ORDER-1:0] o_data
);
  always_comb begin
    o_data = i_data;
    for (int l = 0; l <= ORDER; l++) begin
      if (i_count[l]) o_data = o_data << (2**l);
    end
  end
endmodule

// File: rtl/norm.sv
// Two-stage valid/ready left-normalizer: S1 captures operand and leading
// count, S2 captures the shifted result. Full throughput, latency 2.
module norm
  import norm_pkg::*;
#(
  parameter int ORDER = 3
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  norm_if.slave bus
);
  localparam int W = 2**ORDER;

  logic           w_s1_adv;
  logic           w_s2_adv;
  cix_op_e        w_op;
  logic [ORDER:0] w_cix_count;
  logic           w_cix_zero;
  logic [W-1:0]   w_shifted;

  logic           r_s1_valid;
  logic [W-1:0]   r_s1_data;
  logic [ORDER:0] r_s1_count;
  logic           r_s1_all;

  logic           r_s2_valid;
  logic [W-1:0]   r_s2_data;
  logic [ORDER:0] r_s2_count;
  logic           r_s2_all;

  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_op     = norm_cix_op(bus.in_mode);

  cix #(.ORDER(ORDER)) u_cix (
    .i_op    (w_op),
    .i_data  (bus.in_data),
    .o_count (w_cix_count),
    .o_zero  (w_cix_zero)
  );

  shl_norm #(.ORDER(ORDER)) u_shl (
    .i_data  (r_s1_data),
    .i_count (r_s1_count),
    .o_data  (w_shifted)
  );

  // Data registers load only on a valid advance so they stay quiet when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_count <= '0;
      r_s1_all   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_data  <= bus.in_data;
        r_s1_count <= w_cix_count;
        r_s1_all   <= w_cix_zero;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_count <= '0;
      r_s2_all   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data  <= w_shifted;
        r_s2_count <= r_s1_count;
        r_s2_all   <= r_s1_all;
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_count = r_s2_count;
  assign bus.out_all   = r_s2_all;

endmodule

// File: tb/tb_norm.sv
// Scoreboard bench for norm at ORDER=3: drivers push expected results,
// a negedge monitor pops and compares whatever the block presents.
module tb_norm;
  localparam int ORDER = 3;

  typedef struct {
    logic [7:0] d;
    logic [3:0] c;
    logic       a;
    int         cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   chk_lat = 0;
  bit   rand_rdy = 0;
  bit   prev_stall = 0;
  int   bp_full_seen = 0;
  int   n_inflight;
  item_t q[$];
  item_t it;

  norm_if #(.ORDER(ORDER)) bus ();

  norm #(.ORDER(ORDER)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic item_t model(input logic m, input logic [7:0] d);
    item_t r;
    int c = 0;
    for (int i = 7; i >= 0; i--) begin
      if (d[i] != m) break;
      c++;
    end
    r.c   = 4'(c);
    r.a   = (c == 8);
    r.d   = (c == 8) ? 8'h00 : (d << c);
    r.cyc = 0;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the operand is accepted.
  task automatic send(input logic m, input logic [7:0] d,
                      input logic [7:0] ed, input logic [3:0] ec, input logic ea);
    int tries = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      #1;
      if (bus.in_ready) begin
        q.push_back('{d: ed, c: ec, a: ea, cyc: cyc});
        break;
      end
      tries++;
      if (tries > 100) begin
        chk("accept_timeout", 32'(tries), 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic m, input logic [7:0] d);
    item_t e = model(m, d);
    send(m, d, e.d, e.c, e.a);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 32'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      n_inflight = q.size();
      chk("in_ready", bus.in_ready, !(n_inflight == 2 && !bus.out_ready));
      if (n_inflight == 2 && !bus.out_ready) bp_full_seen++;
      if (prev_stall) chk("stall_hold_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (n_inflight == 0) begin
          chk("spurious_out_valid", bus.out_valid, 0);
        end else begin
          it = q[0];
          chk("out_data", bus.out_data, it.d);
          chk("out_count", bus.out_count, it.c);
          chk("out_all", bus.out_all, it.a);
          if (bus.out_ready) begin
            if (chk_lat) chk("latency", 32'(cyc - it.cyc), 2);
            void'(q.pop_front());
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_all", bus.out_all, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Leading-zero directed vectors, back to back, with latency check.
    chk_lat = 1;
    send(0, 8'h13, 8'h98, 4'd3, 1'b0);
    send(0, 8'h01, 8'h80, 4'd7, 1'b0);
    send(0, 8'h00, 8'h00, 4'd8, 1'b1);
    send(0, 8'hFF, 8'hFF, 4'd0, 1'b0);
    send(0, 8'h80, 8'h80, 4'd0, 1'b0);
    send(0, 8'h0F, 8'hF0, 4'd4, 1'b0);
    // Leading-one directed vectors.
    send(1, 8'hE5, 8'h28, 4'd3, 1'b0);
    send(1, 8'hFF, 8'h00, 4'd8, 1'b1);
    send(1, 8'h7F, 8'h7F, 4'd0, 1'b0);
    send(1, 8'h80, 8'h00, 4'd1, 1'b0);
    send(1, 8'h00, 8'h00, 4'd0, 1'b0);
    drain();

    // Back-pressure: 10 operands with a 3-cycle consumer stall.
    chk_lat = 0;
    bp_full_seen = 0;
    fork
      for (int i = 0; i < 10; i++) send_m(i[0], 8'(8'h11 * i + 8'h03));
      begin
        idle(3);
        bus.out_ready = 1'b0;
        idle(3);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_both_full_seen", 32'(bp_full_seen > 0), 1);

    // Reset with both stages full and the consumer stalled.
    bus.out_ready = 1'b0;
    send(0, 8'h13, 8'h98, 4'd3, 1'b0);
    send(1, 8'hE5, 8'h28, 4'd3, 1'b0);
    chk("pre_rst_in_ready", bus.in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("post_rst_quiet", bus.out_valid, 0);
    end

    // Exhaustive sweep at full throughput.
    chk_lat = 1;
    for (int m = 0; m < 2; m++)
      for (int d = 0; d < 256; d++) send_m(m[0], d[7:0]);
    drain();

    // Random valid/ready stream checked against the reference model.
    chk_lat = 0;
    rand_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      send_m(1'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_rdy = 0;
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
